// File: rtl/hps_ext_pkg.sv
// Shared constants and event record layout for the HPS extension event queue.
package hps_ext_pkg;

  localparam logic [15:0] UIO_MOUSE    = 16'h0004;
  localparam logic [15:0] UIO_KEYBOARD = 16'h0005;
  localparam logic [15:0] UIO_KBD_OSD  = 16'h0006;
  localparam logic [15:0] CMD_RD_DEF   = 16'h002C;
  localparam logic [15:0] CMD_WR_DEF   = 16'h002D;

  localparam logic [1:0] EVT_MOUSE0 = 2'd0;
  localparam logic [1:0] EVT_MOUSE1 = 2'd1;
  localparam logic [1:0] EVT_KBD    = 2'd2;
  localparam logic [1:0] EVT_OSD    = 2'd3;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] data;
  } evt_t;

endpackage

// File: rtl/hps_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only alongside a pop.
module hps_evt_fifo
  import hps_ext_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  evt_t                     din,
  output evt_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hps_ext_evq.sv
// HPS EXT_BUS UIO decoder: read-back bank, atomic write bank, buffered kbd/mouse events.
module hps_ext_evq
  import hps_ext_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_RD     = 8,
  parameter int unsigned NUM_WR     = 4,
  parameter logic [15:0] CMD_RD     = CMD_RD_DEF,
  parameter logic [15:0] CMD_WR     = CMD_WR_DEF
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  inout  wire  [35:0]           EXT_BUS,
  output logic                  io_strobe,
  output logic                  io_uio,
  output logic                  io_fpga,
  output logic [15:0]           io_din,
  input  logic [15:0]           fpga_dout,
  input  logic [16*NUM_RD-1:0]  rd_data,
  output logic [16*NUM_WR-1:0]  wr_data,
  output logic                  wr_commit,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [1:0]            evt_type,
  output logic [7:0]            evt_data,
  output logic                  evt_overflow,
  input  logic                  ovf_clr,
  output logic [2:0]            mouse_buttons
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]        byte_cnt;
  logic [15:0]       cmd;
  logic              dout_en;
  logic [15:0]       io_dout;
  logic              uio_q;
  logic              uio_fall;
  logic [15:0]       shadow [NUM_WR];
  logic [NUM_WR-1:0] dirty;
  logic [15:0]       rd_word;
  logic              strobe_act;
  logic              evt_push;
  logic              evt_pop;
  evt_t              evt_in;
  evt_t              evt_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign io_strobe     = EXT_BUS[33];
  assign io_uio        = EXT_BUS[34];
  assign io_fpga       = EXT_BUS[35];
  assign io_din        = EXT_BUS[31:16];
  assign EXT_BUS[15:0] = io_fpga ? fpga_dout : io_dout;
  assign EXT_BUS[32]   = dout_en | io_fpga;

  assign uio_fall   = uio_q & ~io_uio;
  assign strobe_act = io_uio & io_strobe;
  assign evt_valid  = ~fifo_empty;
  assign evt_pop    = evt_valid & evt_ready;
  assign evt_type   = evt_head.typ;
  assign evt_data   = evt_head.data;

  // Read-back word for the current byte slot; zero outside 1..NUM_RD.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (byte_cnt == 5'(i + 1)) rd_word = rd_data[16*i +: 16];
    end
    if (cmd != CMD_RD) rd_word = '0;
  end

  always_comb begin
    evt_push      = 1'b0;
    evt_in.typ    = EVT_KBD;
    evt_in.data   = io_din[7:0];
    if (strobe_act) begin
      if (cmd == UIO_MOUSE && byte_cnt == 5'd1) begin
        evt_push   = 1'b1;
        evt_in.typ = EVT_MOUSE0;
      end else if (cmd == UIO_MOUSE && byte_cnt == 5'd2) begin
        evt_push   = 1'b1;
        evt_in.typ = EVT_MOUSE1;
      end else if (cmd == UIO_KEYBOARD && byte_cnt == 5'd1) begin
        evt_push   = 1'b1;
        evt_in.typ = EVT_KBD;
      end else if (cmd == UIO_KBD_OSD && byte_cnt == 5'd1) begin
        evt_push   = 1'b1;
        evt_in.typ = EVT_OSD;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_cnt      <= '0;
      cmd           <= '0;
      dout_en       <= 1'b0;
      io_dout       <= '0;
      uio_q         <= 1'b0;
      dirty         <= '0;
      wr_data       <= '0;
      wr_commit     <= 1'b0;
      mouse_buttons <= '0;
      for (int i = 0; i < NUM_WR; i++) shadow[i] <= '0;
    end else begin
      uio_q     <= io_uio;
      wr_commit <= 1'b0;
      if (!io_uio) begin
        byte_cnt <= '0;
        dout_en  <= 1'b0;
        io_dout  <= '0;
      end else if (io_strobe) begin
        if (byte_cnt != 5'd31) byte_cnt <= byte_cnt + 5'd1;
        io_dout <= rd_word;
        if (byte_cnt == 5'd0) begin
          cmd     <= io_din;
          dout_en <= (io_din == CMD_RD) || (io_din == CMD_WR);
        end else if (cmd == CMD_WR) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (byte_cnt == 5'(i + 1)) begin
              shadow[i] <= io_din;
              dirty[i]  <= 1'b1;
            end
          end
        end
        if (cmd == UIO_MOUSE && byte_cnt == 5'd3) mouse_buttons <= io_din[2:0];
      end
      // Commit happens on the falling edge while cmd still holds the write code.
      if (uio_fall) begin
        cmd <= '0;
        if (cmd == CMD_WR && |dirty) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (dirty[i]) wr_data[16*i +: 16] <= shadow[i];
          end
          wr_commit <= 1'b1;
          dirty     <= '0;
        end
      end
    end
  end

  // A drop outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      evt_overflow <= 1'b0;
    end else if (evt_push && fifo_full && !evt_pop) begin
      evt_overflow <= 1'b1;
    end else if (ovf_clr) begin
      evt_overflow <= 1'b0;
    end
  end

  hps_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (evt_push),
    .pop   (evt_pop),
    .din   (evt_in),
    .dout  (evt_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_hps_ext_evq.sv
// Directed bench for hps_ext_evq: read-back, write commit, reset abort, event FIFO, mouse.
module tb_hps_ext_evq;

  localparam int unsigned NRD   = 8;
  localparam int unsigned NWR   = 4;
  localparam int unsigned DEPTH = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               strobe = 1'b0;
  logic               uio = 1'b0;
  logic               fpga = 1'b0;
  logic [15:0]        din = '0;
  logic [15:0]        fpga_dout = '0;
  logic [16*NRD-1:0]  rd_data;
  logic               evt_ready = 1'b0;
  logic               ovf_clr = 1'b0;

  wire  [35:0]        ext_bus;
  wire                io_strobe, io_uio, io_fpga;
  wire  [15:0]        io_din;
  wire  [16*NWR-1:0]  wr_data;
  wire                wr_commit, evt_valid, evt_overflow;
  wire  [1:0]         evt_type;
  wire  [7:0]         evt_data;
  wire  [2:0]         mouse_buttons;

  int checks = 0;
  int failures = 0;

  assign ext_bus[35:33] = {fpga, uio, strobe};
  assign ext_bus[31:16] = din;

  always #5 clk = ~clk;

  hps_ext_evq #(
    .FIFO_DEPTH (DEPTH),
    .NUM_RD     (NRD),
    .NUM_WR     (NWR),
    .CMD_RD     (16'h002C),
    .CMD_WR     (16'h002D)
  ) dut (
    .clk_sys       (clk),
    .reset         (reset),
    .EXT_BUS       (ext_bus),
    .io_strobe     (io_strobe),
    .io_uio        (io_uio),
    .io_fpga       (io_fpga),
    .io_din        (io_din),
    .fpga_dout     (fpga_dout),
    .rd_data       (rd_data),
    .wr_data       (wr_data),
    .wr_commit     (wr_commit),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_type      (evt_type),
    .evt_data      (evt_data),
    .evt_overflow  (evt_overflow),
    .ovf_clr       (ovf_clr),
    .mouse_buttons (mouse_buttons)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] d);
    @(negedge clk);
    din    = d;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic start_uio();
    @(negedge clk);
    uio = 1'b1;
  endtask

  // Returns at the negedge just after the falling-edge cycle was clocked.
  task automatic stop_uio();
    @(negedge clk);
    uio = 1'b0;
    @(negedge clk);
  endtask

  task automatic kbd(input logic [7:0] k);
    start_uio();
    xfer(16'h0005);
    xfer({8'h00, k});
    stop_uio();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) rd_data[16*i +: 16] = 16'hA000 + 16'(i);
    rd_data[15:0]  = 16'h8001;
    rd_data[31:16] = 16'h0280;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_data", 64'(wr_data), 64'h0);
    chk("rst_wr_commit", 64'(wr_commit), 64'h0);
    chk("rst_evt_valid", 64'(evt_valid), 64'h0);
    chk("rst_overflow", 64'(evt_overflow), 64'h0);
    chk("rst_buttons", 64'(mouse_buttons), 64'h0);
    chk("rst_bus_oe", 64'(ext_bus[32]), 64'h0);
    chk("rst_bus_dout", 64'(ext_bus[15:0]), 64'h0);

    fpga = 1'b1;
    fpga_dout = 16'hBEEF;
    #1;
    chk("fpga_dout", 64'(ext_bus[15:0]), 64'hBEEF);
    chk("fpga_oe", 64'(ext_bus[32]), 64'h1);
    @(negedge clk);
    fpga = 1'b0;

    // Read-back
    start_uio();
    xfer(16'h002C);
    chk("rd_oe", 64'(ext_bus[32]), 64'h1);
    xfer(16'h0000);
    chk("rd_word0", 64'(ext_bus[15:0]), 64'h8001);
    xfer(16'h0000);
    chk("rd_word1", 64'(ext_bus[15:0]), 64'h0280);
    stop_uio();
    chk("rd_oe_idle", 64'(ext_bus[32]), 64'h0);
    chk("rd_dout_idle", 64'(ext_bus[15:0]), 64'h0);

    // Write with commit
    start_uio();
    xfer(16'h002D);
    xfer(16'h0010);
    xfer(16'h0200);
    chk("wr_no_early_commit", 64'(wr_commit), 64'h0);
    chk("wr_data_pre", 64'(wr_data), 64'h0);
    stop_uio();
    chk("wr_commit_pulse", 64'(wr_commit), 64'h1);
    chk("wr_data_commit", 64'(wr_data), 64'h0000_0000_0200_0010);
    @(negedge clk);
    chk("wr_commit_end", 64'(wr_commit), 64'h0);

    // Reset mid-write discards shadow
    start_uio();
    xfer(16'h002D);
    xfer(16'h1234);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stop_uio();
    chk("abort_commit", 64'(wr_commit), 64'h0);
    chk("abort_wr_data", 64'(wr_data), 64'h0);
    @(negedge clk);
    chk("abort_commit2", 64'(wr_commit), 64'h0);
    chk("abort_wr_data2", 64'(wr_data), 64'h0);

    // Overfill the FIFO
    for (int k = 1; k <= 10; k++) kbd(8'(k));
    chk("ovf_valid", 64'(evt_valid), 64'h1);
    chk("ovf_flag", 64'(evt_overflow), 64'h1);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain1_valid", 64'(evt_valid), 64'h1);
      chk("drain1_type", 64'(evt_type), 64'h2);
      chk("drain1_data", 64'(evt_data), 64'(i + 1));
      @(negedge clk);
    end
    evt_ready = 1'b0;
    chk("drain1_empty", 64'(evt_valid), 64'h0);

    // Full with simultaneous push and pop, then clear racing a drop
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(evt_overflow), 64'h0);
    for (int k = 8'h11; k <= 8'h18; k++) kbd(8'(k));
    chk("full_no_ovf", 64'(evt_overflow), 64'h0);
    start_uio();
    xfer(16'h0005);
    @(negedge clk);
    din = 16'h0019;
    strobe = 1'b1;
    evt_ready = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    evt_ready = 1'b0;
    stop_uio();
    chk("pushpop_no_ovf", 64'(evt_overflow), 64'h0);
    chk("pushpop_head", 64'(evt_data), 64'h12);
    start_uio();
    xfer(16'h0005);
    @(negedge clk);
    din = 16'h001A;
    strobe = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    ovf_clr = 1'b0;
    chk("drop_beats_clr", 64'(evt_overflow), 64'h1);
    stop_uio();
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2_valid", 64'(evt_valid), 64'h1);
      chk("drain2_data", 64'(evt_data), 64'(8'h12 + i));
      @(negedge clk);
    end
    evt_ready = 1'b0;
    chk("drain2_empty", 64'(evt_valid), 64'h0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", 64'(evt_overflow), 64'h0);

    // Mouse transaction
    start_uio();
    xfer(16'h0004);
    chk("mouse_cmd_no_push", 64'(evt_valid), 64'h0);
    xfer(16'h0008);
    chk("mouse_valid_rise", 64'(evt_valid), 64'h1);
    xfer(16'h00FE);
    xfer(16'h0005);
    stop_uio();
    chk("mouse_buttons", 64'(mouse_buttons), 64'h5);
    chk("mouse0_type", 64'(evt_type), 64'h0);
    chk("mouse0_data", 64'(evt_data), 64'h08);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("mouse1_type", 64'(evt_type), 64'h1);
    chk("mouse1_data", 64'(evt_data), 64'hFE);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("mouse_empty", 64'(evt_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hps_ext_evq.md
Name: hps_ext_evq

Overview:
Parametrised successor of the Minimig HPS extension decoder. It decodes UIO commands from the HPS EXT_BUS and buffers keyboard and mouse events in an event FIFO, so back-to-back strobes are never lost. It serves a generic read-back bank of NUM_RD status words and a write bank of NUM_WR words that commits atomically at end of transaction. It sits between the top-level EXT_BUS and the Minimig core (keyboard/mouse controller, video position logic).

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2
NUM_RD, 8, readable 16-bit words served by CMD_RD; 1..30
NUM_WR, 4, writable 16-bit words accepted by CMD_WR; 1..30
CMD_RD, 'h2C, read-back command code
CMD_WR, 'h2D, write/commit command code

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
EXT_BUS  inout  36  HPS bus: [15:0] data to HPS, [31:16] data from HPS, [32] dout enable, [33] strobe, [34] uio, [35] fpga
io_strobe  out  1  EXT_BUS[33]
io_uio  out  1  EXT_BUS[34]
io_fpga  out  1  EXT_BUS[35]
io_din  out  16  EXT_BUS[31:16]
fpga_dout  in  16  FPGA-channel read data, driven onto EXT_BUS[15:0] while io_fpga=1
rd_data  in  16*NUM_RD  flattened read bank; word i at [16i+15:16i]
wr_data  out  16*NUM_WR  committed write bank
wr_commit  out  1  one-cycle pulse when wr_data updates
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pops the head when evt_valid & evt_ready
evt_type  out  2  head type: 0 mouse byte 1, 1 mouse movement, 2 keyboard, 3 OSD key
evt_data  out  8  head data byte
evt_overflow  out  1  sticky, set when an event is dropped
ovf_clr  in  1  clears evt_overflow
mouse_buttons  out  3  last mouse button state

Behaviour:
- Clock and reset: clk_sys, one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 (wr_data, wr_commit, evt_valid, evt_overflow, mouse_buttons). Internal state also clears: byte_cnt, cmd, dout_en, io_dout, shadow, FIFO pointers and count.
- Bus drive: EXT_BUS[15:0] = io_fpga ? fpga_dout : io_dout. EXT_BUS[32] = dout_en | io_fpga.
- Idle (io_uio=0): byte_cnt, dout_en and io_dout clear to 0; cmd clears to 0 one cycle after an io_uio falling edge.
- Strobe (io_uio & io_strobe):
  - byte_cnt increments and saturates at 31.
  - io_dout defaults to 0.
  - At byte_cnt=0: cmd <= io_din; dout_en <= (io_din==CMD_RD || io_din==CMD_WR).
- CMD_RD: at byte k, 1<=k<=NUM_RD, io_dout <= rd_data word k-1, registered on the strobe edge. For k>NUM_RD, io_dout = 0.
- CMD_WR: at byte k, 1<=k<=NUM_WR, shadow word k-1 <= io_din and the word is flagged dirty. Words beyond NUM_WR are ignored.
- Commit: on io_uio falling edge, detected by registered io_uio, with cmd==CMD_WR and any dirty flag set:
  - dirty words are copied to wr_data, clean words keep their value;
  - wr_commit pulses for one cycle, the cycle after the edge;
  - dirty flags clear.
- Events (cmd 'h04 mouse, 'h05 keyboard, 'h06 OSD):
  - mouse byte 1 pushes {0, din[7:0]};
  - mouse byte 2 pushes {1, din[7:0]};
  - mouse byte 3 sets mouse_buttons <= din[2:0] with no push;
  - keyboard byte 1 pushes {2, din[7:0]};
  - OSD byte 1 pushes {3, din[7:0]}.
- FIFO timing: a push is written on the strobe edge; evt_valid rises the next cycle. evt_type/evt_data are combinational from the head entry.
- FIFO boundaries:
  - Full and pushing without a same-cycle pop: event dropped, evt_overflow <= 1.
  - Full with simultaneous push and pop: both performed, no overflow.
  - Empty: evt_valid=0 and pops are ignored.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Overflow flag: ovf_clr clears evt_overflow; if ovf_clr and a drop occur in the same cycle, set wins.
- Reset mid-transaction: shadow and dirty flags are discarded, no wr_commit, FIFO is flushed.

Decomposition:
- Package hps_ext_pkg holds:
  - UIO command codes: UIO_MOUSE 'h04, UIO_KEYBOARD 'h05, UIO_KBD_OSD 'h06, defaults for CMD_RD and CMD_WR;
  - event type constants EVT_MOUSE0, EVT_MOUSE1, EVT_KBD, EVT_OSD;
  - the 10-bit event record layout {type[1:0], data[7:0]}.
- Sub-module hps_evt_fifo: synchronous FIFO with parameter DEPTH, data width 10, push/pop/full/empty/count.

Test Plan:
- CMD_RD, 3 strobes with rd_data word0='h8001, word1='h0280 -> EXT_BUS[32]=1; io_dout 'h8001 then 'h0280 on the following reads.
- CMD_WR with 'h0010, 'h0200, then io_uio low -> wr_data word0='h0010, word1='h0200, words 2-3 unchanged; wr_commit high exactly 1 cycle.
- CMD_WR, one word, then reset asserted before io_uio falls -> wr_data stays 0, no wr_commit.
- 10 keyboard transactions ('h01..'h0A) with evt_ready=0 (FIFO_DEPTH=8) -> 8 entries, evt_overflow=1; draining yields 'h01..'h08 in order, all type 2.
- FIFO full, keyboard push in the same cycle as evt_ready=1 -> count stays 8, no overflow; ovf_clr together with a drop -> evt_overflow remains 1.
- Mouse transaction 'h08, 'hFE, 'h05 -> events {0,'h08} then {1,'hFE}; mouse_buttons='b101.
